// File: rtl/apb_master.sv
// APB master bridge: accepts single CPU-side requests and runs them as
// APB SETUP/ACCESS transfers to one of four slaves mapped at 0x1000_0000.
// Unmapped addresses and slaves that stall too long complete with err=1.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;
    logic        complete;
    logic        fail;

    // Slave window 0x1000_0000..0x1000_3FFF, 4 KiB per slave; anything else is unmapped.
    function automatic logic [3:0] decode(input logic [31:0] a);
        logic [3:0] sel;
        sel = '0;
        if (a[31:14] == 18'h04000) begin
            sel[a[13:12]] = 1'b1;
        end
        return sel;
    endfunction

    // Return-path mux driven only by the selected slave; an empty PSEL marks an unmapped access.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (PSEL)
            4'b0001: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
            4'b0010: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
            4'b0100: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
            4'b1000: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
            default: begin sel_ready = 1'b0;    sel_rdata = '0;      end
        endcase
    end

    // Completion is decided in the ACCESS cycle itself, so ready/err/rdata follow PREADY combinationally.
    // wait_cnt holds the number of earlier stalled ACCESS cycles, hence the TIMEOUT-1 compare.
    always_comb begin
        timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
        complete    = (state == ACCESS) && ((PSEL == '0) || sel_ready || timeout_hit);
        fail        = (state == ACCESS) && ((PSEL == '0) || (!sel_ready && timeout_hit));
        ready       = complete;
        err         = fail;
        rdata       = (complete && !fail && !PWRITE) ? sel_rdata : '0;
    end

    // Transfer FSM with registered APB outputs; a completing ACCESS may chain straight into SETUP.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state    <= IDLE;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    if (transfer) begin
                        PADDR  <= addr;
                        PWRITE <= write;
                        PWDATA <= wdata;
                        PSEL   <= decode(addr);
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (complete) begin
                        PENABLE <= 1'b0;
                        if (transfer) begin
                            PADDR  <= addr;
                            PWRITE <= write;
                            PWDATA <= wdata;
                            PSEL   <= decode(addr);
                            state  <= SETUP;
                        end else begin
                            PSEL  <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: inputs are driven on the falling edge and
// outputs are sampled 1 ns later, so each sample shows the cycle started by
// the preceding rising edge.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int unsigned total  = 0;
    int unsigned passed = 0;

    apb_master #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    always #5 PCLK = ~PCLK;

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        PRESET = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        PRDATA0 = '0; PRDATA1 = '0; PRDATA2 = '0; PRDATA3 = '0;
        PREADY0 = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b0; PREADY3 = 1'b0;
        tick(); tick(); #1;
        total++; if (PSEL !== 4'b0000) $display("FAIL rst_psel: got %b exp 0000", PSEL); else passed++;
        total++; if (PENABLE !== 1'b0) $display("FAIL rst_penable: got %b exp 0", PENABLE); else passed++;
        total++; if (ready !== 1'b0 || err !== 1'b0) $display("FAIL rst_ready_err: got %b%b exp 00", ready, err); else passed++;
        total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) $display("FAIL rst_regs: got %h %h %b exp 0 0 0", PADDR, PWDATA, PWRITE); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h exp 0", rdata); else passed++;
        tick(); PRESET = 1'b1;
    endtask

    task automatic test_write();
        tick(); transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h0000_0003; #1;
        total++; if (PSEL !== 4'b0000) $display("FAIL wr_c0_psel: got %b exp 0000", PSEL); else passed++;
        tick(); transfer = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; #1;
        total++; if (PSEL !== 4'b0001 || PENABLE !== 1'b0) $display("FAIL wr_c1_setup: got %b/%b exp 0001/0", PSEL, PENABLE); else passed++;
        total++; if (PADDR !== 32'h1000_0000 || PWDATA !== 32'h3 || PWRITE !== 1'b1) $display("FAIL wr_c1_regs: got %h %h %b exp 10000000 00000003 1", PADDR, PWDATA, PWRITE); else passed++;
        tick(); #1;
        total++; if (PENABLE !== 1'b1 || ready !== 1'b0) $display("FAIL wr_c2_access: got pen=%b rdy=%b exp 1 0", PENABLE, ready); else passed++;
        tick(); PREADY0 = 1'b1; #1;
        total++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) $display("FAIL wr_c3_done: got %b %b %h exp 1 0 0", ready, err, rdata); else passed++;
        tick(); PREADY0 = 1'b0; #1;
        total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0) $display("FAIL wr_c4_idle: got %b %b %b exp 0000 0 0", PSEL, PENABLE, ready); else passed++;
        total++; if (PADDR !== 32'h1000_0000 || PWDATA !== 32'h3) $display("FAIL wr_c4_hold: got %h %h exp 10000000 00000003", PADDR, PWDATA); else passed++;
    endtask

    task automatic test_read();
        PRDATA0 = 32'hFFFF_FFFF; PRDATA1 = 32'hFFFF_FFFF; PRDATA2 = 32'hDEAD_BEEF; PRDATA3 = 32'hFFFF_FFFF;
        tick(); transfer = 1'b1; write = 1'b0; addr = 32'h1000_2004;
        tick(); transfer = 1'b0; #1;
        total++; if (PSEL !== 4'b0100 || PENABLE !== 1'b0) $display("FAIL rd_setup: got %b/%b exp 0100/0", PSEL, PENABLE); else passed++;
        tick(); PREADY2 = 1'b1; #1;
        total++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF) $display("FAIL rd_done: got %b %b %h exp 1 0 deadbeef", ready, err, rdata); else passed++;
        tick(); PREADY2 = 1'b0; #1;
        total++; if (ready !== 1'b0 || rdata !== 32'h0 || PSEL !== 4'b0000) $display("FAIL rd_after: got %b %h %b exp 0 0 0000", ready, rdata, PSEL); else passed++;
    endtask

    task automatic test_unmapped();
        PREADY0 = 1'b1; PREADY1 = 1'b1; PREADY2 = 1'b1; PREADY3 = 1'b1;
        tick(); transfer = 1'b1; write = 1'b0; addr = 32'h2000_0000;
        tick(); transfer = 1'b0; #1;
        total++; if (PSEL !== 4'b0000 || ready !== 1'b0) $display("FAIL um_setup: got %b %b exp 0000 0", PSEL, ready); else passed++;
        tick(); #1;
        total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b1) $display("FAIL um_access: got %b %b exp 0000 1", PSEL, PENABLE); else passed++;
        total++; if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) $display("FAIL um_done: got %b %b %h exp 1 1 0", ready, err, rdata); else passed++;
        tick(); PREADY0 = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b0; PREADY3 = 1'b0; #1;
        total++; if (PENABLE !== 1'b0 || ready !== 1'b0) $display("FAIL um_idle: got %b %b exp 0 0", PENABLE, ready); else passed++;
    endtask

    task automatic test_timeout();
        int unsigned n;
        logic got_rdy, got_err, early_err;
        logic [31:0] got_rdata;
        n = 0; got_rdy = 1'b0; got_err = 1'b0; got_rdata = '0; early_err = 1'b0;
        PRDATA1 = 32'h5555_AAAA;
        tick(); transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
        tick(); transfer = 1'b0; #1;
        total++; if (PSEL !== 4'b0010) $display("FAIL to_setup: got %b exp 0010", PSEL); else passed++;
        while (!got_rdy && n < 40) begin
            tick(); #1; n++;
            if (ready === 1'b1) begin got_rdy = 1'b1; got_err = err; got_rdata = rdata; end
            else if (err !== 1'b0) early_err = 1'b1;
        end
        total++; if (n !== 16 || got_rdy !== 1'b1) $display("FAIL to_cycles: got %0d rdy=%b exp 16 1", n, got_rdy); else passed++;
        total++; if (got_err !== 1'b1 || got_rdata !== 32'h0 || early_err !== 1'b0) $display("FAIL to_err: got %b %h early=%b exp 1 0 0", got_err, got_rdata, early_err); else passed++;
        tick(); #1;
        total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) $display("FAIL to_drop: got %b %b exp 0000 0", PSEL, PENABLE); else passed++;
    endtask

    task automatic test_back_to_back();
        tick(); transfer = 1'b1; write = 1'b1; addr = 32'h1000_3000; wdata = 32'hA5A5_0001;
        tick(); addr = 32'h1000_1111; write = 1'b0; #1;
        total++; if (PSEL !== 4'b1000 || PADDR !== 32'h1000_3000 || PWRITE !== 1'b1) $display("FAIL b2b_setup_ignore: got %b %h %b exp 1000 10003000 1", PSEL, PADDR, PWRITE); else passed++;
        tick(); PREADY3 = 1'b1; addr = 32'h1000_0008; write = 1'b0; #1;
        total++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) $display("FAIL b2b_wr_done: got %b %b %h exp 1 0 0", ready, err, rdata); else passed++;
        tick(); transfer = 1'b0; PREADY3 = 1'b0; #1;
        total++; if (PSEL !== 4'b0001 || PENABLE !== 1'b0 || PADDR !== 32'h1000_0008 || PWRITE !== 1'b0) $display("FAIL b2b_no_bubble: got %b %b %h %b exp 0001 0 10000008 0", PSEL, PENABLE, PADDR, PWRITE); else passed++;
        tick(); PREADY3 = 1'b1; PRDATA3 = 32'hFFFF_FFFF; PRDATA0 = 32'h1234_5678; #1;
        total++; if (ready !== 1'b0 || rdata !== 32'h0) $display("FAIL b2b_unsel_ready: got %b %h exp 0 0", ready, rdata); else passed++;
        tick(); PREADY0 = 1'b1; #1;
        total++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h1234_5678) $display("FAIL b2b_rd_done: got %b %b %h exp 1 0 12345678", ready, err, rdata); else passed++;
        tick(); PREADY0 = 1'b0; PREADY3 = 1'b0; #1;
        total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) $display("FAIL b2b_idle: got %b %b exp 0000 0", PSEL, PENABLE); else passed++;
    endtask

    task automatic test_reset_mid();
        tick(); transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'hCAFE_0000;
        tick(); transfer = 1'b0;
        tick(); #1;
        total++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010) $display("FAIL rm_in_access: got %b %b exp 1 0010", PENABLE, PSEL); else passed++;
        #2; PRESET = 1'b0; PREADY1 = 1'b1; #1;
        total++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0 || PADDR !== 32'h0) $display("FAIL rm_async: got %b %b %b %h exp 0000 0 0 0", PSEL, PENABLE, ready, PADDR); else passed++;
        tick(); #1;
        total++; if (ready !== 1'b0 || PENABLE !== 1'b0) $display("FAIL rm_held: got %b %b exp 0 0", ready, PENABLE); else passed++;
        PRESET = 1'b1; PREADY1 = 1'b0;
        tick(); transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000; #1;
        total++; if (PSEL !== 4'b0000 || ready !== 1'b0) $display("FAIL rm_idle: got %b %b exp 0000 0", PSEL, ready); else passed++;
        tick(); transfer = 1'b0; #1;
        total++; if (PSEL !== 4'b0001 || PENABLE !== 1'b0) $display("FAIL rm_restart: got %b %b exp 0001 0", PSEL, PENABLE); else passed++;
        tick(); PREADY0 = 1'b1; #1;
        total++; if (ready !== 1'b1 || rdata !== 32'h1234_5678) $display("FAIL rm_done: got %b %h exp 1 12345678", ready, rdata); else passed++;
        tick(); PREADY0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
